// File: rtl/cvxif_pau_queue_if.sv
// CVXIF issue/register/result channels plus the start/done port to the posit execution unit.
// slave = the queue itself, master = core side and execution unit.
interface cvxif_pau_queue_if #(
    parameter int XLEN  = 32,
    parameter int PAU_N = 32,
    parameter int ID_W  = 4
);
    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      issue_req_instr;
    logic [ID_W-1:0]  issue_req_id;
    logic             issue_resp_accept;
    logic             issue_resp_writeback;
    logic [1:0]       issue_resp_register_read;
    logic             register_valid;
    logic             register_ready;
    logic [ID_W-1:0]  register_id;
    logic [XLEN-1:0]  register_rs0;
    logic [XLEN-1:0]  register_rs1;
    logic [1:0]       register_rs_valid;
    logic             exu_start;
    logic [2:0]       exu_op;
    logic [PAU_N-1:0] exu_a;
    logic [PAU_N-1:0] exu_b;
    logic             exu_done;
    logic [PAU_N-1:0] exu_result;
    logic             result_valid;
    logic             result_ready;
    logic [ID_W-1:0]  result_id;
    logic [XLEN-1:0]  result_data;
    logic             result_err;
    logic             busy;

    modport slave (
        input  issue_valid, issue_req_instr, issue_req_id,
               register_valid, register_id, register_rs0, register_rs1, register_rs_valid,
               exu_done, exu_result, result_ready,
        output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
               register_ready, exu_start, exu_op, exu_a, exu_b,
               result_valid, result_id, result_data, result_err, busy
    );

    modport master (
        output issue_valid, issue_req_instr, issue_req_id,
               register_valid, register_id, register_rs0, register_rs1, register_rs_valid,
               exu_done, exu_result, result_ready,
        input  issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
               register_ready, exu_start, exu_op, exu_a, exu_b,
               result_valid, result_id, result_data, result_err, busy
    );
endinterface

// File: rtl/cvxif_pau_queue.sv
// In-order CVXIF posit instruction queue: operand capture to result_valid is 3 cycles with a 1-cycle unit.
// Issue stalls when DEPTH entries are outstanding; a held result blocks the next dispatch.
module cvxif_pau_queue #(
    parameter int XLEN    = 32,
    parameter int PAU_N   = 32,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    cvxif_pau_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   PINC = (PW+1)'(1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT} state_e;
    state_e state_q, state_d;

    logic [ID_W-1:0]  id_q  [DEPTH];
    logic [2:0]       op_q  [DEPTH];
    logic [PAU_N-1:0] a_q   [DEPTH];
    logic [PAU_N-1:0] b_q   [DEPTH];
    logic             err_q [DEPTH];

    // Four wrap-aware pointers: tail (enqueue), opr (next to get operands),
    // dsp (next to execute), head (oldest not yet retired through result handshake).
    logic [PW:0]      tail_q, opr_q, dsp_q, head_q;
    logic [CW-1:0]    cnt_q;
    logic             rslt_vld_q, rslt_err_q;
    logic [ID_W-1:0]  rslt_id_q;
    logic [PAU_N-1:0] rslt_dat_q;

    logic [PW:0]      count;
    logic [PW-1:0]    dsp_idx;
    logic             dec_hit, enq, cap, cap_err, retire, res_free;
    logic             head_rdy, head_err, timeout;
    logic             ld, ld_err;
    logic [PAU_N-1:0] ld_dat;
    logic             unused_bits;

    assign count   = tail_q - head_q;
    assign dsp_idx = dsp_q[PW-1:0];
    assign dec_hit = (bus.issue_req_instr[6:0] == 7'b1111011) &&
                     (bus.issue_req_instr[31:25] == 7'd0) && !bus.issue_req_instr[14];

    assign bus.issue_ready              = (count < FULL);
    assign bus.issue_resp_accept        = bus.issue_valid & dec_hit;
    assign bus.issue_resp_writeback     = 1'b1;
    assign bus.issue_resp_register_read = {2{bus.issue_resp_accept}};
    assign enq = bus.issue_resp_accept & bus.issue_ready;

    assign bus.register_ready = (opr_q != tail_q);
    assign cap     = bus.register_valid & bus.register_ready & (bus.register_rs_valid == 2'b11);
    assign cap_err = (bus.register_id != id_q[opr_q[PW-1:0]]);

    assign retire   = rslt_vld_q & bus.result_ready;
    assign res_free = !rslt_vld_q | bus.result_ready;
    // Operands arriving for the dispatch entry this cycle are visible immediately.
    assign head_rdy = (dsp_q != opr_q) | cap;
    assign head_err = (dsp_q != opr_q) ? err_q[dsp_idx] : cap_err;
    assign timeout  = (cnt_q == TMAX);

    assign unused_bits = ^{bus.issue_req_instr, bus.register_rs0, bus.register_rs1};

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (head_rdy && !head_err && res_free) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (bus.exu_done || timeout) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ld            = 1'b0;
        ld_err        = 1'b0;
        ld_dat        = '0;
        bus.exu_start = 1'b0;
        bus.exu_op    = '0;
        bus.exu_a     = '0;
        bus.exu_b     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (head_rdy && head_err && res_free) begin
                    ld     = 1'b1;
                    ld_err = 1'b1;
                end
            end
            ST_START: begin
                bus.exu_start = 1'b1;
                bus.exu_op    = op_q[dsp_idx];
                bus.exu_a     = a_q[dsp_idx];
                bus.exu_b     = b_q[dsp_idx];
            end
            ST_WAIT: begin
                bus.exu_op = op_q[dsp_idx];
                bus.exu_a  = a_q[dsp_idx];
                bus.exu_b  = b_q[dsp_idx];
                if (bus.exu_done) begin
                    ld     = 1'b1;
                    ld_dat = bus.exu_result;
                end else if (timeout) begin
                    ld     = 1'b1;
                    ld_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q     <= '0;
            opr_q      <= '0;
            dsp_q      <= '0;
            head_q     <= '0;
            cnt_q      <= '0;
            rslt_vld_q <= 1'b0;
            rslt_err_q <= 1'b0;
            rslt_id_q  <= '0;
            rslt_dat_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]  <= '0;
                op_q[i]  <= '0;
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                err_q[i] <= 1'b0;
            end
        end else begin
            if (enq) begin
                id_q[tail_q[PW-1:0]] <= bus.issue_req_id;
                op_q[tail_q[PW-1:0]] <= bus.issue_req_instr[14:12];
                tail_q               <= tail_q + PINC;
            end
            if (cap) begin
                a_q[opr_q[PW-1:0]]   <= bus.register_rs0[PAU_N-1:0];
                b_q[opr_q[PW-1:0]]   <= bus.register_rs1[PAU_N-1:0];
                err_q[opr_q[PW-1:0]] <= cap_err;
                opr_q                <= opr_q + PINC;
            end
            if (ld)     dsp_q  <= dsp_q + PINC;
            if (retire) head_q <= head_q + PINC;
            cnt_q <= (state_q == ST_IDLE) ? '0 : cnt_q + CW'(1);
            if (ld) begin
                rslt_vld_q <= 1'b1;
                rslt_err_q <= ld_err;
                rslt_id_q  <= id_q[dsp_idx];
                rslt_dat_q <= ld_dat;
            end else if (bus.result_ready) begin
                rslt_vld_q <= 1'b0;
            end
        end
    end

    assign bus.result_valid = rslt_vld_q;
    assign bus.result_id    = rslt_id_q;
    assign bus.result_data  = XLEN'(rslt_dat_q);
    assign bus.result_err   = rslt_err_q;
    assign bus.busy         = (count != '0);
endmodule

// File: tb/tb_cvxif_pau_queue.sv
// Directed and randomized bench for cvxif_pau_queue with a behavioural execution unit and result model.
module tb_cvxif_pau_queue;
    localparam int XLEN = 32, PAU_N = 32, ID_W = 4, DEPTH = 4, TIMEOUT = 255;

    logic clk;
    logic rst;
    int   cyc_n = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    cvxif_pau_queue_if #(.XLEN(XLEN), .PAU_N(PAU_N), .ID_W(ID_W)) bus ();

    cvxif_pau_queue #(.XLEN(XLEN), .PAU_N(PAU_N), .ID_W(ID_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT))
        dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Behavioural execution unit: answers exu_lat cycles after start from the held operands.
    int          exu_lat   = 1;
    bit          exu_mode  = 1'b0;
    bit          fixed_en  = 1'b0;
    logic [31:0] fixed_val = '0;
    logic        rsp_done  = 1'b0;
    logic        man_done  = 1'b0;
    logic [31:0] rsp_res   = '0;
    int          n_start   = 0;
    int          start_cyc = 0;

    assign bus.exu_done   = rsp_done | man_done;
    assign bus.exu_result = rsp_res;

    function automatic logic [31:0] exu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a * b;
            default: return a ^ b;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.exu_start === 1'b1) begin
                n_start++;
                start_cyc = cyc_n;
                if (!exu_mode) begin
                    repeat (exu_lat) @(posedge clk);
                    #1;
                    rsp_res  = fixed_en ? fixed_val : exu_fn(bus.exu_op, bus.exu_a, bus.exu_b);
                    rsp_done = 1'b1;
                    @(posedge clk);
                    #1 rsp_done = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, ".issue_ready"},  bus.issue_ready, 1);
        check({p, ".accept"},       bus.issue_resp_accept, 0);
        check({p, ".reg_ready"},    bus.register_ready, 0);
        check({p, ".exu_start"},    bus.exu_start, 0);
        check({p, ".exu_op"},       bus.exu_op, 0);
        check({p, ".exu_a"},        bus.exu_a, 0);
        check({p, ".exu_b"},        bus.exu_b, 0);
        check({p, ".result_valid"}, bus.result_valid, 0);
        check({p, ".result_id"},    bus.result_id, 0);
        check({p, ".result_data"},  bus.result_data, 0);
        check({p, ".result_err"},   bus.result_err, 0);
        check({p, ".busy"},         bus.busy, 0);
    endtask

    task automatic do_issue(input string tag, input logic [31:0] ins, input logic [ID_W-1:0] id,
                            input logic exp_acc);
        bus.issue_valid     = 1'b1;
        bus.issue_req_instr = ins;
        bus.issue_req_id    = id;
        #1;
        check({tag, ".accept"}, bus.issue_resp_accept, exp_acc);
        check({tag, ".regread"}, bus.issue_resp_register_read, {2{exp_acc}});
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
    endtask

    task automatic do_regs(input string tag, input logic [ID_W-1:0] id, input logic [31:0] a,
                           input logic [31:0] b, output int cap_cyc);
        bit ok;
        ok      = 1'b0;
        cap_cyc = 0;
        bus.register_valid    = 1'b1;
        bus.register_id       = id;
        bus.register_rs0      = a;
        bus.register_rs1      = b;
        bus.register_rs_valid = 2'b11;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.register_ready === 1'b1) begin
                ok      = 1'b1;
                cap_cyc = cyc_n;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
        end
        bus.register_valid    = 1'b0;
        bus.register_rs_valid = 2'b00;
        check({tag, ".captured"}, ok, 1);
    endtask

    task automatic wait_valid(input int lim, output int vcyc, output bit ok);
        ok   = 1'b0;
        vcyc = 0;
        for (int i = 0; i < lim; i++) begin
            if (bus.result_valid === 1'b1) begin
                ok   = 1'b1;
                vcyc = cyc_n;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic get_result(input string tag, input logic [ID_W-1:0] eid, input logic [31:0] edat,
                              input logic eerr, input int stall, output int vcyc);
        bit ok;
        wait_valid(600, vcyc, ok);
        check({tag, ".valid"}, ok, 1);
        if (ok) begin
            repeat (stall) begin
                @(posedge clk);
                #1;
            end
            bus.result_ready = 1'b1;
            #1;
            check({tag, ".id"},   bus.result_id, eid);
            check({tag, ".data"}, bus.result_data, edat);
            check({tag, ".err"},  bus.result_err, eerr);
            @(posedge clk);
            #1 bus.result_ready = 1'b0;
        end
    endtask

    initial begin
        int              cc, cc2, vc, t0, s0, nb, nacc, kind;
        bit              ok, mm;
        logic [31:0]     w, ra, rb, va[DEPTH], vb[DEPTH];
        logic [2:0]      op;
        logic [ID_W-1:0] id, bid[DEPTH];
        logic [2:0]      bop[DEPTH];
        logic            exp_acc;

        rst = 1'b1;
        bus.issue_valid = 1'b0; bus.issue_req_instr = '0; bus.issue_req_id = '0;
        bus.register_valid = 1'b0; bus.register_id = '0; bus.register_rs0 = '0;
        bus.register_rs1 = '0; bus.register_rs_valid = '0; bus.result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single add with a fixed unit answer and 1-cycle latency.
        fixed_en = 1'b1; fixed_val = 32'h4800_0000; exu_lat = 1; s0 = n_start;
        do_issue("add", 32'h0000_007B, 4'd3, 1'b1);
        check("add.writeback", bus.issue_resp_writeback, 1);
        check("add.busy", bus.busy, 1);
        do_regs("add", 4'd3, 32'h4000_0000, 32'h4000_0000, cc);
        get_result("add", 4'd3, 32'h4800_0000, 1'b0, 0, vc);
        check("add.latency", vc - cc, 3);
        check("add.starts", n_start - s0, 1);
        fixed_en = 1'b0;

        // Fill the queue, then drain in order.
        for (int i = 0; i < DEPTH; i++) do_issue("fill", 32'h0000_207B, ID_W'(i), 1'b1);
        check("fill.issue_ready", bus.issue_ready, 0);
        check("fill.busy", bus.busy, 1);
        bus.issue_valid = 1'b1; bus.issue_req_instr = 32'h0000_207B; bus.issue_req_id = 4'd4;
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
        check("fill.still_full", bus.issue_ready, 0);
        exu_lat = $urandom_range(1, 4);
        for (int i = 0; i < DEPTH; i++) begin
            va[i] = $urandom; vb[i] = $urandom;
            do_regs("fill", ID_W'(i), va[i], vb[i], cc);
        end
        for (int i = 0; i < DEPTH; i++) get_result("fill", ID_W'(i), exu_fn(3'd2, va[i], vb[i]), 1'b0, 0, vc);
        check("fill.ready_after", bus.issue_ready, 1);
        check("fill.busy_after", bus.busy, 0);

        // Decode rejects.
        do_issue("rej_f7", 32'h0200_007B, 4'd9, 1'b0);
        do_issue("rej_f3", 32'h0000_507B, 4'd9, 1'b0);
        check("rej.busy", bus.busy, 0);
        check("rej.reg_ready", bus.register_ready, 0);

        // Timeout, then the next instruction executes normally.
        exu_mode = 1'b1; exu_lat = 1;
        do_issue("to1", 32'h0000_007B, 4'd7, 1'b1);
        do_issue("to2", 32'h0000_107B, 4'd8, 1'b1);
        s0 = n_start;
        ra = $urandom; rb = $urandom;
        do_regs("to1", 4'd7, $urandom, $urandom, cc);
        do_regs("to2", 4'd8, ra, rb, cc2);
        check("to.first_start", n_start - s0, 1);
        t0 = start_cyc;
        exu_mode = 1'b0;
        get_result("to1", 4'd7, 32'h0, 1'b1, 0, vc);
        check("to.cycles", vc - t0, 256);
        get_result("to2", 4'd8, exu_fn(3'd1, ra, rb), 1'b0, 0, vc);
        check("to.second_start", n_start - s0, 2);

        // ID mismatch skips execution.
        s0 = n_start;
        do_issue("mm", 32'h0000_007B, 4'd5, 1'b1);
        do_regs("mm", 4'd6, $urandom, $urandom, cc);
        get_result("mm", 4'd5, 32'h0, 1'b1, 0, vc);
        check("mm.no_start", n_start - s0, 0);

        // Result backpressure holds the slot and blocks the next dispatch.
        exu_lat = 1; s0 = n_start;
        va[0] = $urandom; vb[0] = $urandom; va[1] = $urandom; vb[1] = $urandom;
        do_issue("bp1", 32'h0000_007B, 4'd1, 1'b1);
        do_issue("bp2", 32'h0000_007B, 4'd2, 1'b1);
        do_regs("bp1", 4'd1, va[0], vb[0], cc);
        do_regs("bp2", 4'd2, va[1], vb[1], cc);
        wait_valid(20, vc, ok);
        check("bp.valid", ok, 1);
        for (int k = 0; k < 10; k++) begin
            check("bp.hold_valid", bus.result_valid, 1);
            check("bp.hold_id", bus.result_id, 1);
            check("bp.hold_data", bus.result_data, exu_fn(3'd0, va[0], vb[0]));
            @(posedge clk);
            #1;
        end
        check("bp.one_start", n_start - s0, 1);
        get_result("bp1", 4'd1, exu_fn(3'd0, va[0], vb[0]), 1'b0, 0, vc);
        get_result("bp2", 4'd2, exu_fn(3'd0, va[1], vb[1]), 1'b0, 0, vc);

        // Reset while waiting on the unit; a late done must not produce a result.
        exu_mode = 1'b1; s0 = n_start;
        do_issue("rw", 32'h0000_207B, 4'd4, 1'b1);
        do_regs("rw", 4'd4, $urandom, $urandom, cc);
        for (int i = 0; i < 10 && n_start == s0; i++) begin
            @(posedge clk);
            #1;
        end
        check("rw.started", n_start - s0, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("rw");
        rst = 1'b0; man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rw.no_result", bus.result_valid, 0);
        check("rw.busy", bus.busy, 0);
        check("rw.issue_ready", bus.issue_ready, 1);
        exu_mode = 1'b0;

        // Randomized batches checked against the decode rule and the unit model.
        for (int bt = 0; bt < 12; bt++) begin
            nb = $urandom_range(1, DEPTH);
            exu_lat = $urandom_range(1, 5);
            nacc = 0;
            while (nacc < nb) begin
                w = $urandom;
                op = 3'($urandom_range(0, 3));
                w[6:0] = 7'b1111011; w[31:25] = 7'd0; w[14:12] = op;
                kind = $urandom_range(0, 5);
                if (kind == 0) w[31:25] = 7'($urandom_range(1, 127));
                else if (kind == 1) w[14:12] = 3'($urandom_range(4, 7));
                else if (kind == 2) w[6:0] = 7'($urandom_range(0, 127));
                exp_acc = (w[6:0] == 7'h7B) && (w[31:25] == 7'd0) && (w[14:12] < 3'd4);
                id = ID_W'($urandom);
                do_issue("rnd", w, id, exp_acc);
                if (exp_acc) begin
                    bid[nacc] = id;
                    bop[nacc] = w[14:12];
                    nacc++;
                end
            end
            for (int j = 0; j < nb; j++) begin
                va[j] = $urandom; vb[j] = $urandom;
                mm = ($urandom_range(0, 5) == 0);
                do_regs("rnd", mm ? bid[j] + 4'd1 : bid[j], va[j], vb[j], cc);
                if (mm) begin
                    va[j] = 32'h0; vb[j] = 32'hFFFF_FFFF;
                end
            end
            for (int j = 0; j < nb; j++) begin
                if (va[j] == 32'h0 && vb[j] == 32'hFFFF_FFFF)
                    get_result("rnd", bid[j], 32'h0, 1'b1, $urandom_range(0, 3), vc);
                else
                    get_result("rnd", bid[j], exu_fn(bop[j], va[j], vb[j]), 1'b0, $urandom_range(0, 3), vc);
            end
            check("rnd.busy", bus.busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cvxif_pau_queue.md
Name: cvxif_pau_queue

Overview:
Next-generation CVXIF posit coprocessor front-end. Accepts up to DEPTH outstanding custom-3 posit instructions, each tagged with a CVXIF ID. Operands are collected in order and dispatched one at a time to an external posit execution unit (add/sub/mul/div) over a start/done handshake. Results return in order with their ID, with a timeout error path. It sits between the core's CVXIF port and the posit arithmetic units.

Parameters:
XLEN, 32, register and result width
PAU_N, 32, posit operand width (PAU_N <= XLEN)
ID_W, 4, CVXIF instruction ID width
DEPTH, 4, outstanding-instruction queue depth (power of 2, >= 2)
TIMEOUT, 255, max cycles waiting for exu_done before error

Ports:
Clock and reset: clk is the clock; rst is the reset, synchronous, active-high.
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  instruction offered
issue_ready  out  1  queue can take an instruction
issue_req_instr  in  32  instruction word
issue_req_id  in  ID_W  instruction ID
issue_resp_accept  out  1  instruction decoded as ours (combinational)
issue_resp_writeback  out  1  constant 1
issue_resp_register_read  out  2  2'b11 when accepting, else 2'b00
register_valid  in  1  operands offered
register_ready  out  1  operand slot available
register_id  in  ID_W  ID the operands belong to
register_rs0  in  XLEN  rs1 value
register_rs1  in  XLEN  rs2 value
register_rs_valid  in  2  per-operand valid
exu_start  out  1  one-cycle start pulse to execution unit
exu_op  out  3  func3 of dispatched instruction
exu_a  out  PAU_N  operand a, held while executing
exu_b  out  PAU_N  operand b, held while executing
exu_done  in  1  execution unit finished
exu_result  in  PAU_N  execution unit result
result_valid  out  1  result available
result_ready  in  1  core takes result
result_id  out  ID_W  ID of result
result_data  out  XLEN  result, zero-extended from PAU_N
result_err  out  1  1 = timeout or ID mismatch, data 0
busy  out  1  any entry occupied

Behaviour:
- Decode: opcode[6:0]==7'b1111011, func7==0, func3 in {000 add, 001 sub, 010 mul, 011 div}; anything else gets accept=0 and is not enqueued.
- Enqueue: on issue_valid & issue_ready & decode hit, store {id, func3} at the tail. issue_ready = (count < DEPTH), from registered count; no same-cycle bypass on a retire when full.
- Operands: strictly issue order. register_ready=1 when the oldest entry without operands exists. Capture on register_valid & register_ready & rs_valid==2'b11. If register_id != entry id, mark the entry err; it skips execution.
- Dispatch FSM: IDLE -> START -> WAIT -> IDLE.
  - IDLE -> START when the head entry has operands, is not err, and the result register is empty or draining this cycle.
  - START: exu_start=1 for exactly one cycle, exu_a/exu_b/exu_op driven from the entry and held through WAIT. Move to WAIT.
  - WAIT: 8-bit-wide-enough counter increments each cycle. On exu_done, latch result and return to IDLE. If counter reaches TIMEOUT first, latch err with data 0 and return to IDLE. exu_done in the START cycle is ignored.
  - An err-marked head entry goes straight to the result register without asserting exu_start.
- Result register: single slot. result_valid is held with stable id/data/err until result_ready; the entry frees on the handshake. Latency from operand capture to result_valid with a 1-cycle exu is 3 cycles (capture, START, WAIT+done, then valid).
- Simultaneous enqueue, operand capture and retire in one cycle: all honoured; count = count + enq - retire.
- Pointers wrap modulo DEPTH.
- Reset, including mid-operation: queue empties, FSM goes to IDLE, counters clear. Outputs at reset: issue_ready=1 (after the first clock), issue_resp_accept=0, register_ready=0, exu_start=0, exu_op=0, exu_a=0, exu_b=0, result_valid=0, result_id=0, result_data=0, result_err=0, busy=0. A late exu_done after reset is ignored.

Test Plan:
- Single add: instr 0x0000007B|func3 000, id 3; rs 0x40000000 and 0x40000000; exu returns 0x48000000 one cycle after start -> result_valid with id 3, data 0x48000000, err 0, exactly one exu_start pulse.
- Fill queue: 4 back-to-back mul issues ids 0..3 with no operands -> issue_ready=0 on the 5th. Supply operands and drain -> results arrive as ids 0,1,2,3 in order, then issue_ready=1.
- Decode reject: func7=0000001 or func3=101 -> accept=0, count unchanged, busy=0.
- Timeout: exu_done never asserted with TIMEOUT=255 -> result_err=1, data 0, at 256 cycles after start; the next queued instruction then dispatches normally.
- ID mismatch: issue id 5, operands with register_id 6 -> no exu_start; result id 5, err=1.
- Backpressure and reset: result_ready held low for 10 cycles -> result stable and no second dispatch completes. rst asserted in WAIT -> all outputs at reset values the next cycle; exu_done the following cycle produces no result.
